// File: rtl/alu16_mul_seq.sv
// alu16_mul_seq: shift-and-add 16x16 -> 16 multiply sequencer that borrows the
// CPU's shared combinational ALU (x+y only) instead of owning an adder.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for operands; ALU held at ZERO code
// ADD    | acc <= acc + m (current multiplier bit is set)
// DBL    | m <= m + m, q <= q >> 1, bitcnt <= bitcnt + 1
// DONE   | product presented until out_ready; ALU held at ZERO code
module alu16_mul_seq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DBL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_acc;
  logic [15:0] r_m;
  logic [15:0] r_q;
  logic [4:0]  r_bitcnt;

  logic        w_accept;
  logic [15:0] w_q_shr;
  logic        w_finish;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_q_shr  = r_q >> 1;
  // Fixed-latency builds walk all 16 multiplier bits even past the MSB;
  // extra doublings only touch m, which no longer feeds acc.
  assign w_finish = EARLY_EXIT ? (w_q_shr == 16'd0) : (r_bitcnt == 5'd15);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (EARLY_EXIT && (b == 16'd0)) begin
            w_next = S_DONE;
          end else if (b[0]) begin
            w_next = S_ADD;
          end else begin
            w_next = S_DBL;
          end
        end
      end
      S_ADD: w_next = S_DBL;
      S_DBL: begin
        if (w_finish) begin
          w_next = S_DONE;
        end else if (w_q_shr[0]) begin
          w_next = S_ADD;
        end else begin
          w_next = S_DBL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake, product and ALU drive decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    product   = 16'd0;
    // ZERO code by default so the shared ALU sees a quiet, known input
    alu_x     = 16'd0;
    alu_y     = 16'd0;
    alu_zx    = 1'b1;
    alu_nx    = 1'b0;
    alu_zy    = 1'b1;
    alu_ny    = 1'b0;
    alu_f     = 1'b1;
    alu_no    = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_ADD: begin
        alu_x  = r_acc;
        alu_y  = r_m;
        alu_zx = 1'b0;
        alu_zy = 1'b0;
      end
      S_DBL: begin
        alu_x  = r_m;
        alu_y  = r_m;
        alu_zx = 1'b0;
        alu_zy = 1'b0;
      end
      S_DONE: begin
        out_valid = 1'b1;
        product   = r_acc;
      end
      default: ;
    endcase
  end

  // Datapath registers: load on accept, update from the ALU result in ADD/DBL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= 16'd0;
      r_m      <= 16'd0;
      r_q      <= 16'd0;
      r_bitcnt <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc    <= 16'd0;
            r_m      <= a;
            r_q      <= b;
            r_bitcnt <= 5'd0;
          end
        end
        S_ADD: r_acc <= alu_out;
        S_DBL: begin
          r_m      <= alu_out;
          r_q      <= w_q_shr;
          r_bitcnt <= r_bitcnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_mul_seq.sv
// Bench for alu16_mul_seq: two instances (early-exit and fixed-latency) share
// one operand bus, each wired to its own behavioural Hack-style ALU.
// Stimulus pushes hand-computed products and latencies into a scoreboard that
// a free-running monitor pops when a DUT raises out_valid.
module tb_alu16_mul_seq;

  logic             clk;
  logic             rst_n;
  logic [15:0]      a;
  logic [15:0]      b;
  logic             out_ready;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       out_valid;
  logic [1:0][15:0] product;
  logic [1:0][15:0] alu_x;
  logic [1:0][15:0] alu_y;
  logic [1:0][15:0] alu_out;
  logic [1:0]       alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          dut;
    logic [15:0] prod;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  mon_active;
  exp_t        mon_cur[2];

  // index 0: fixed latency, index 1: early exit
  alu16_mul_seq #(.EARLY_EXIT(1'b0)) u_dut_fix (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .product(product[0]), .alu_x(alu_x[0]), .alu_y(alu_y[0]),
    .alu_zx(alu_zx[0]), .alu_nx(alu_nx[0]), .alu_zy(alu_zy[0]),
    .alu_ny(alu_ny[0]), .alu_f(alu_f[0]), .alu_no(alu_no[0]),
    .alu_out(alu_out[0])
  );

  alu16_mul_seq #(.EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .product(product[1]), .alu_x(alu_x[1]), .alu_y(alu_y[1]),
    .alu_zx(alu_zx[1]), .alu_nx(alu_nx[1]), .alu_zy(alu_zy[1]),
    .alu_ny(alu_ny[1]), .alu_f(alu_f[1]), .alu_no(alu_no[1]),
    .alu_out(alu_out[1])
  );

  function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic zx, input logic nx, input logic zy,
                                            input logic ny, input logic f, input logic no);
    logic [15:0] xx, yy, r;
    xx = zx ? 16'd0 : x;
    xx = nx ? ~xx : xx;
    yy = zy ? 16'd0 : y;
    yy = ny ? ~yy : yy;
    r  = f ? (xx + yy) : (xx & yy);
    r  = no ? ~r : r;
    return r;
  endfunction

  always_comb begin
    alu_out = '0;
    for (int d = 0; d < 2; d++) begin
      alu_out[d] = alu_model(alu_x[d], alu_y[d], alu_zx[d], alu_nx[d],
                             alu_zy[d], alu_ny[d], alu_f[d], alu_no[d]);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor: ALU code every cycle; scoreboard pop when out_valid rises
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic [5:0] ctl;
        ctl = {alu_zx[d], alu_nx[d], alu_zy[d], alu_ny[d], alu_f[d], alu_no[d]};
        if (in_ready[d] || out_valid[d]) begin
          check($sformatf("alu_zero_code[%0d]", d), {26'd0, ctl, alu_x[d], alu_y[d]},
                {26'd0, 6'b101010, 32'd0});
        end else begin
          check($sformatf("alu_add_code[%0d]", d), {58'd0, ctl}, {58'd0, 6'b000010});
        end
        if (out_valid[d]) begin
          if (!mon_active[d]) begin
            mon_active[d] = 1'b1;
            if (sb_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_out_valid[%0d]: got product %h expected none", d, product[d]);
              mon_cur[d] = '{d, product[d], 0, cyc};
            end else begin
              mon_cur[d] = sb_q.pop_front();
              check($sformatf("sb_dut[%0d]", d), 64'(mon_cur[d].dut), 64'(d));
              check($sformatf("latency[%0d]", d), 64'(cyc - mon_cur[d].acc_cyc),
                    64'(mon_cur[d].lat));
            end
          end
          check($sformatf("product[%0d]", d), {48'd0, product[d]}, {48'd0, mon_cur[d].prod});
        end else begin
          mon_active[d] = 1'b0;
          check($sformatf("product_idle_zero[%0d]", d), {48'd0, product[d]}, 64'd0);
        end
      end
    end else begin
      mon_active = 2'b00;
    end
  end

  // Issue one operand pair to DUT d; lat counts clocks after the accept edge
  task automatic accept_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                           input logic [15:0] prod, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      fail_now("accept_wait");
      return;
    end
    a = av;
    b = bv;
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{d, prod, lat, cyc});
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) fail_now("idle_wait");
  endtask

  typedef struct {
    int          dut;
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  // latency (early exit): popcount(b) + msb_index(b) + 1, b==0 -> DONE at accept edge
  // latency (fixed):      popcount(b) + 16
  vec_t vecs[$] = '{
    '{1, 16'h0003, 16'h0005, 16'h000F, 5},
    '{1, 16'h1234, 16'h0000, 16'h0000, 0},
    '{1, 16'h0000, 16'h00FF, 16'h0000, 16},
    '{1, 16'hFFFE, 16'h0003, 16'hFFFA, 4},
    '{1, 16'hFFFF, 16'hFFFF, 16'h0001, 32},
    '{1, 16'h0100, 16'h0100, 16'h0000, 10},
    '{0, 16'h0007, 16'h0002, 16'h000E, 17},
    '{0, 16'hFFFF, 16'hFFFF, 16'h0001, 32},
    '{0, 16'h1234, 16'h0000, 16'h0000, 16}
  };

  initial begin
    int n;
    rst_n      = 1'b0;
    in_valid   = 2'b00;
    out_ready  = 1'b1;
    a          = 16'd0;
    b          = 16'd0;
    mon_active = 2'b00;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_state[%0d]", d), {45'd0, in_ready[d], out_valid[d], product[d]},
            {45'd0, 1'b1, 1'b0, 16'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      accept_op(vecs[i].dut, vecs[i].av, vecs[i].bv, vecs[i].prod, vecs[i].lat);
      wait_idle(vecs[i].dut);
    end

    // Backpressure: result must hold, new operands refused
    out_ready = 1'b0;
    accept_op(1, 16'h0003, 16'h0005, 16'h000F, 5);
    n = 0;
    while (!out_valid[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[1]) fail_now("bp_done_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {62'd0, out_valid[1], in_ready[1]}, {62'd0, 1'b1, 1'b0});
      if (i == 3) begin
        a = 16'hAAAA;
        b = 16'h0001;
        in_valid[1] = 1'b1;
      end
      if (i == 4) in_valid[1] = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {62'd0, out_valid[1], in_ready[1]}, {62'd0, 1'b0, 1'b1});

    // Asynchronous reset in the middle of an operation
    accept_op(1, 16'h00FF, 16'h00FF, 16'hFE01, 16);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", {45'd0, out_valid[1], in_ready[1], product[1]}, {45'd0, 1'b0, 1'b1, 16'd0});
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    accept_op(1, 16'h0002, 16'h0002, 16'h0004, 3);
    wait_idle(1);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
